// File: rtl/led_pkg.sv
// Shared mode encoding for the LED pattern sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_MIRROR  = 2'd3
  } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// Per-bit 2-flop synchroniser plus stability counter; level and rise outputs are registered.
// A bit's level changes only after DEBOUNCE_CYCLES consecutive differing synchronised samples.
module btn_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] sync1_q, sync2_q, level_q, rise_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      rise_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        // Any sample agreeing with the accepted level restarts the stability window.
        if (sync2_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q[i] <= sync2_q[i];
          rise_q[i]  <= sync2_q[i];
          cnt_q[i]   <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: prescaled tick drives count / scan / breathe / mirror patterns.
// o_led and o_tick are registered (1-cycle latency); a debounced press of i_btn[MODE_BTN] cycles the mode.
module led_pattern_seq #(
  parameter int N_LED           = 8,
  parameter int N_BTN           = 7,
  parameter int MODE_BTN        = 1,
  parameter int PRESC_W         = 18,
  parameter int PWM_W           = 8,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int RESET_MODE      = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_LED-1:0] o_led,
  output logic [1:0]       o_mode,
  output logic             o_tick
);
  import led_pkg::*;

  localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int N_MIR = (N_LED < N_BTN) ? N_LED : N_BTN;

  logic [N_BTN-1:0]   btn_db, btn_rise;
  logic               press, unused_ok;
  logic [PRESC_W-1:0] presc_q;
  logic               tick_q;
  mode_t              mode_q, mode_d;
  logic [N_LED-1:0]   step_q, step_d, led_q, led_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_dn_q, dir_dn_d;
  logic [PWM_W-1:0]   duty_q, duty_d, pwm_q;
  logic               duty_dn_q, duty_dn_d;

  btn_debounce #(
    .WIDTH           (N_BTN),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn),
    .o_level (btn_db),
    .o_rise  (btn_rise)
  );

  assign press     = btn_rise[MODE_BTN];
  assign unused_ok = ^{btn_rise, btn_db};

  // A press restarts the pattern and takes priority over a coincident tick.
  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    pos_d     = pos_q;
    dir_dn_d  = dir_dn_q;
    duty_d    = duty_q;
    duty_dn_d = duty_dn_q;
    if (press) begin
      mode_d    = mode_t'(mode_q + 2'd1);
      step_d    = '0;
      pos_d     = '0;
      dir_dn_d  = 1'b0;
      duty_d    = '0;
      duty_dn_d = 1'b0;
    end else if (tick_q) begin
      case (mode_q)
        MODE_COUNT: step_d = step_q + N_LED'(1);
        MODE_SCAN: begin
          if (N_LED > 1) begin
            dir_dn_d = dir_dn_q ^ (dir_dn_q ? (pos_q == '0) : (pos_q == POS_W'(N_LED - 1)));
            pos_d    = dir_dn_d ? (pos_q - POS_W'(1)) : (pos_q + POS_W'(1));
          end
        end
        MODE_BREATHE: begin
          duty_dn_d = duty_dn_q ^ (duty_dn_q ? (duty_q == '0) : (&duty_q));
          duty_d    = duty_dn_d ? (duty_q - PWM_W'(1)) : (duty_q + PWM_W'(1));
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_COUNT:   led_d = step_q;
      MODE_SCAN:    led_d = N_LED'(1) << pos_q;
      MODE_BREATHE: led_d = {N_LED{pwm_q < duty_q}};
      default: for (int i = 0; i < N_MIR; i++) led_d[i] = btn_db[i];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      pwm_q     <= '0;
      mode_q    <= mode_t'(RESET_MODE[1:0]);
      step_q    <= '0;
      pos_q     <= '0;
      dir_dn_q  <= 1'b0;
      duty_q    <= '0;
      duty_dn_q <= 1'b0;
      led_q     <= '0;
    end else begin
      presc_q   <= presc_q + PRESC_W'(1);
      tick_q    <= &presc_q;
      pwm_q     <= pwm_q + PWM_W'(1);
      mode_q    <= mode_d;
      step_q    <= step_d;
      pos_q     <= pos_d;
      dir_dn_q  <= dir_dn_d;
      duty_q    <= duty_d;
      duty_dn_q <= duty_dn_d;
      led_q     <= led_d;
    end
  end

  assign o_led  = led_q;
  assign o_mode = mode_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomized bench for led_pattern_seq against a tick-counting reference model.
module tb_led_pattern_seq;

  localparam int N_LED = 8, N_BTN = 7, MODE_BTN = 1, PRESC_W = 4, PWM_W = 4;
  localparam int DEB = 4, RESET_MODE = 0;

  logic             i_clk, i_rst_n;
  logic [N_BTN-1:0] i_btn;
  logic [N_LED-1:0] o_led;
  logic [1:0]       o_mode;
  logic             o_tick;

  led_pattern_seq #(
    .N_LED(N_LED), .N_BTN(N_BTN), .MODE_BTN(MODE_BTN), .PRESC_W(PRESC_W),
    .PWM_W(PWM_W), .DEBOUNCE_CYCLES(DEB), .RESET_MODE(RESET_MODE)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn),
    .o_led(o_led), .o_mode(o_mode), .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: patterns are functions of ticks seen since the last mode entry.
  int unsigned      m_cyc, m_n;
  int               m_mode;
  bit               m_tick;
  logic [N_BTN-1:0] m_r1, m_r2, m_db, m_rise;
  logic [N_BTN-1:0] m_hist[$];
  logic [N_LED-1:0] m_led;

  function automatic int tri_wave(int unsigned n, int m);
    int k;
    if (m == 0) return 0;
    k = int'(n % (2 * m));
    return (k <= m) ? k : 2 * m - k;
  endfunction

  task automatic model_edge();
    logic [N_LED-1:0] led_n;
    int pwm;
    bit all_diff;
    if (!i_rst_n) begin
      m_cyc = 0; m_n = 0; m_mode = RESET_MODE; m_tick = 0;
      m_r1 = '0; m_r2 = '0; m_db = '0; m_rise = '0; m_led = '0;
      m_hist.delete();
      return;
    end
    pwm = int'(m_cyc % (1 << PWM_W));
    case (m_mode)
      0:       led_n = N_LED'(m_n);
      1:       led_n = N_LED'(1) << tri_wave(m_n, N_LED - 1);
      2:       led_n = {N_LED{pwm < tri_wave(m_n, (1 << PWM_W) - 1)}};
      default: led_n = N_LED'(m_db);
    endcase
    if (m_rise[MODE_BTN]) begin
      m_mode = (m_mode + 1) % 4;
      m_n = 0;
    end else if (m_tick) begin
      m_n++;
    end
    m_tick = (m_cyc % (1 << PRESC_W)) == (1 << PRESC_W) - 1;
    m_cyc++;
    // Level flips once the last DEB synchronised samples all disagree with it.
    m_hist.push_back(m_r2);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    m_rise = '0;
    if (m_hist.size() == DEB) begin
      for (int b = 0; b < N_BTN; b++) begin
        all_diff = 1;
        foreach (m_hist[j]) if (m_hist[j][b] == m_db[b]) all_diff = 0;
        if (all_diff) begin
          m_db[b] = ~m_db[b];
          m_rise[b] = m_db[b];
        end
      end
    end
    m_r2 = m_r1;
    m_r1 = i_btn;
    m_led = led_n;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    chk("led", 32'(o_led), 32'(m_led));
    chk("mode", 32'(o_mode), 32'(m_mode));
    chk("tick", 32'(o_tick), 32'(m_tick));
  endtask

  task automatic press(input int exp_mode);
    int lat;
    lat = 0;
    i_btn[MODE_BTN] = 1'b1;
    while (int'(o_mode) != exp_mode && lat < 40) begin
      cyc();
      lat++;
    end
    chk("press_adv", 32'(o_mode), 32'(exp_mode));
  endtask

  logic [7:0] scan_exp [20] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                                8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
  bit led_hi [600];
  bit tk     [600];

  initial begin
    int ticks, lat, got, kbase, j, hold;
    logic [7:0] prev;
    logic [N_BTN-1:0] v;
    n_chk = 0; n_fail = 0;
    i_clk = 0; i_rst_n = 0; i_btn = '0;
    repeat (3) cyc();
    chk("rst_led", 32'(o_led), 0);
    chk("rst_mode", 32'(o_mode), RESET_MODE);
    chk("rst_tick", 32'(o_tick), 0);

    i_rst_n = 1;
    ticks = 0;
    repeat (64) begin
      cyc();
      if (o_tick) ticks++;
    end
    chk("tick_cnt", 32'(ticks), 4);
    chk("led_64", 32'(o_led), 3);

    // Run COUNT to the wrap while toggling non-mode buttons.
    lat = 0;
    while (o_led != 8'hFF && lat < 4200) begin
      if ($urandom_range(0, 15) == 0) i_btn = N_BTN'($urandom) & ~(N_BTN'(1) << MODE_BTN);
      cyc();
      lat++;
    end
    chk("cnt_ff_seen", 32'(o_led), 32'hFF);
    lat = 0;
    while (o_led == 8'hFF && lat < 20) begin cyc(); lat++; end
    chk("cnt_wrap", 32'(o_led), 0);
    i_btn = '0;
    repeat (DEB + 4) cyc();

    // Bouncy press: one advance, 2 sync + DEB stable + 1 pulse cycles after the stable level.
    i_btn[MODE_BTN] = 1'b1; cyc();
    i_btn[MODE_BTN] = 1'b0; cyc();
    i_btn[MODE_BTN] = 1'b1;
    lat = 0;
    while (o_mode == 2'd0 && lat < 30) begin cyc(); lat++; end
    chk("press_lat", 32'(lat), 32'(2 + DEB + 1));
    chk("mode_scan", 32'(o_mode), 1);
    cyc();
    chk("scan_first", 32'(o_led), 32'h01);

    prev = o_led; got = 0; lat = 0;
    while (got < 20 && lat < 20 * 16 + 32) begin
      if (lat == 12) i_btn[MODE_BTN] = 1'b0;
      cyc();
      lat++;
      if (o_led != prev) begin
        chk("scan_seq", 32'(o_led), 32'(scan_exp[got]));
        got++;
        prev = o_led;
      end
    end
    chk("scan_changes", 32'(got), 20);
    chk("no_double", 32'(o_mode), 1);

    press(2);
    kbase = o_tick ? 1 : 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 3) i_btn[MODE_BTN] = 1'b0;
      cyc();
      led_hi[i] = (o_led == 8'hFF);
      tk[i] = o_tick;
    end
    j = 0;
    for (int i = 0; i + 17 < 600; i++) begin
      if (tk[i]) begin
        int cnt, k;
        j++;
        k = j + kbase;
        cnt = 0;
        for (int s = i + 2; s <= i + 17; s++) cnt += led_hi[s] ? 1 : 0;
        if (k == 8)  chk("brth_d8", 32'(cnt), 8);
        if (k == 15) chk("brth_peak", 32'(cnt), 15);
        if (k == 16) chk("brth_turn", 32'(cnt), 14);
        if (k == 30) chk("brth_zero", 32'(cnt), 0);
      end
    end
    chk("brth_ticks_ok", 32'(j + kbase >= 30), 1);

    press(3);
    i_btn = 7'b0000101;
    repeat (2 + DEB + 4) cyc();
    chk("mirror_05", 32'(o_led), 32'h05);
    repeat (4) begin
      v = N_BTN'($urandom) & ~(N_BTN'(1) << MODE_BTN);
      i_btn = v;
      repeat (2 + DEB + 4) cyc();
      chk("mirror_rand", 32'(o_led), 32'(v));
    end

    press(0);
    i_btn = '0;
    repeat (DEB + 6) cyc();
    press(1);
    i_btn = '0;
    repeat ($urandom_range(20, 80)) cyc();
    i_rst_n = 0;
    cyc();
    chk("rst_mid_led", 32'(o_led), 0);
    chk("rst_mid_mode", 32'(o_mode), RESET_MODE);
    i_rst_n = 1;

    // Random soak: held button patterns with random durations and occasional resets.
    hold = 0;
    repeat (1500) begin
      if (hold == 0) begin
        i_btn = N_BTN'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      i_rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
